// File: rtl/trans_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trans_pkg : shared transaction layout, CRC-8 step and serializer states  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package trans_pkg;

  localparam int TRANS_W     = 128;
  localparam int TRANS_BYTES = 16;

  // Field layout, shared with the upstream validator
  localparam int SENDER_MSB      = 127;
  localparam int SENDER_LSB      = 80;
  localparam int RECEIVER_MSB    = 79;
  localparam int RECEIVER_LSB    = 32;
  localparam int AMOUNT_MSB      = 31;
  localparam int AMOUNT_LSB      = 10;
  localparam int BLOCK_START_BIT = 9;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // One byte of MSB-first CRC-8, no reflection
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trans_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trans_fifo : synchronous DEPTH-entry FIFO with head-of-queue read data    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module trans_fifo
  import trans_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = TRANS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/trans_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trans_serializer : buffers validated transactions and streams them out   |
// | byte by byte; TRANS_SER_CRC_EN appends a CRC-8 byte to each transaction. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module trans_serializer
  import trans_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TRANS_W-1:0]      data_i,
  input  logic                    valid_i,
  output logic [7:0]              byte_o,
  output logic                    byte_valid_o,
  input  logic                    byte_ready_i,
  output logic                    sof_o,
  output logic                    eof_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o
);

`ifdef TRANS_SER_CRC_EN
  localparam logic [4:0] LAST_IDX = 5'd16;
  logic [7:0] crc_q, crc_d;
`else
  localparam logic [4:0] LAST_IDX = 5'd15;
`endif

  ser_state_e         state_q, state_d;
  logic [TRANS_W-1:0] shreg_q, shreg_d;
  logic [4:0]         idx_q, idx_d;
  logic               byte_valid_q, byte_valid_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic               overflow_q, overflow_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TRANS_W-1:0] fifo_rdata;
  logic               hs, load;

  trans_fifo #(
    .DEPTH (DEPTH),
    .W     (TRANS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (data_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Full is judged on the registered level, so a same-cycle pop never rescues a write
  assign fifo_push  = valid_i && !fifo_full;
  assign overflow_d = overflow_q || (valid_i && fifo_full);
  assign hs         = byte_valid_q && byte_ready_i;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    byte_valid_d = byte_valid_q;
    sof_d        = sof_q;
    eof_d        = eof_q;
    load         = 1'b0;
`ifdef TRANS_SER_CRC_EN
    crc_d        = crc_q;
`endif
    case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d      = ST_IDLE;
              byte_valid_d = 1'b0;
              sof_d        = 1'b0;
              eof_d        = 1'b0;
              shreg_d      = '0;
            end
          end else begin
            idx_d   = idx_q + 5'd1;
            sof_d   = 1'b0;
            eof_d   = (idx_d == LAST_IDX);
            shreg_d = {shreg_q[TRANS_W-9:0], 8'h00};
`ifdef TRANS_SER_CRC_EN
            crc_d = crc8_update(crc_q, shreg_q[TRANS_W-1 -: 8]);
            // The CRC byte rides in the top of the shift register after byte 15
            if (idx_q == 5'(TRANS_BYTES - 1)) shreg_d[TRANS_W-1 -: 8] = crc_d;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d      = ST_SEND;
      shreg_d      = fifo_rdata;
      idx_d        = '0;
      byte_valid_d = 1'b1;
      sof_d        = 1'b1;
      eof_d        = 1'b0;
`ifdef TRANS_SER_CRC_EN
      crc_d        = 8'h00;
`endif
    end
  end

  assign fifo_pop = load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef TRANS_SER_CRC_EN
      crc_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      byte_valid_q <= byte_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      overflow_q   <= overflow_d;
`ifdef TRANS_SER_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign byte_o       = shreg_q[TRANS_W-1 -: 8];
  assign byte_valid_o = byte_valid_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_trans_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trans_serializer : directed and random stimulus against a byte-queue   |
// | reference model of trans_serializer.                                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_trans_serializer;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRANS_SER_CRC_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam logic [127:0] W_SEQ = 128'h0102030405060708090A0B0C0D0E0F10;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  data_i;
  logic          valid_i;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i;
  logic          sof_o;
  logic          eof_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;

  trans_serializer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         lvl_m = 0;
  logic       ovf_m = 1'b0;
  int         pos = 0;
  int         tx_done = 0;
  int         gap = 0;
  logic [7:0] last_byte = 8'h00;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [127:0] w);
    logic [135:0] r;
    r = {w, 8'h00};
    for (int i = 135; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic push_model(input logic [127:0] w);
    for (int k = 0; k < 16; k++) exp_q.push_back(w[127 - 8*k -: 8]);
`ifdef TRANS_SER_CRC_EN
    exp_q.push_back(crc_ref(w));
`endif
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic v, input logic [127:0] d, input logic rdy);
    logic hs, pend;
    valid_i      = v;
    data_i       = d;
    byte_ready_i = rdy;
    if (v) begin
      if (lvl_m < DEPTH) begin
        push_model(d);
        lvl_m++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    hs   = byte_valid_o && rdy;
    pend = byte_valid_o && !rdy;
    if (hs) begin
      if (pos == NB - 1) begin
        tx_done++;
        last_byte = byte_o;
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pos = (pos + 1) % NB;
    end
    @(posedge clk);
    #1;
    // A freshly presented first byte marks the pop of one FIFO entry
    if (byte_valid_o && sof_o && !pend) lvl_m--;
    chk("level", level_o, lvl_m);
    chk("overflow", overflow_o, ovf_m);
    if (pend) chk("valid_hold", byte_valid_o, 1);
    if (exp_q.size() == 0) begin
      chk("idle_valid", byte_valid_o, 0);
    end else if (byte_valid_o) begin
      gap = 0;
      chk("byte", byte_o, exp_q[0]);
      chk("sof", sof_o, pos == 0);
      chk("eof", eof_o, pos == NB - 1);
    end else begin
      gap++;
      chk("bubble", gap <= 1, 1);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() > 0 || byte_valid_o); i++) step(1'b0, '0, 1'b1);
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    valid_i      = 1'b0;
    byte_ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_byte", byte_o, 0);
    chk("rst_valid", byte_valid_o, 0);
    chk("rst_sof", sof_o, 0);
    chk("rst_eof", eof_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_overflow", overflow_o, 0);
    exp_q.delete();
    lvl_m = 0;
    ovf_m = 1'b0;
    pos   = 0;
    gap   = 0;
    #2 rst = 1'b0;
  endtask

  initial begin
    int run;
    int tx0;
    rst          = 1'b0;
    valid_i      = 1'b0;
    data_i       = '0;
    byte_ready_i = 1'b0;
    @(posedge clk);
    #1;
    reset_dut();

    // Single word: latency and 16 (or 17) consecutive bytes
    step(1'b1, W_SEQ, 1'b1);
    chk("lat1_valid", byte_valid_o, 0);
    chk("lat1_level", level_o, 1);
    step(1'b0, '0, 1'b1);
    chk("lat2_valid", byte_valid_o, 1);
    chk("lat2_byte", byte_o, 8'h01);
    chk("lat2_sof", sof_o, 1);
    chk("lat2_level", level_o, 0);
    for (int i = 0; i < NB - 1; i++) begin
      step(1'b0, '0, 1'b1);
      chk("run1_valid", byte_valid_o, 1);
    end
    chk("run1_last", byte_o, 8'h10 ^ ((NB == 17) ? crc_ref(W_SEQ) ^ 8'h10 : 8'h00));
    step(1'b0, '0, 1'b1);
    chk("run1_end", byte_valid_o, 0);

    // Backpressure at byte 3
    tx0 = tx_done;
    step(1'b1, W_SEQ, 1'b1);
    for (int i = 0; i < 20 && !(byte_valid_o && pos == 3); i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      chk("stall_byte", byte_o, 8'h04);
    end
    drain(60);
    chk("stall_tx", tx_done - tx0, 1);

    // Fill with sink stalled: first word moves to the shift register, 9 accepted, 10th dropped
    reset_dut();
    tx0 = tx_done;
    for (int i = 0; i < 10; i++) step(1'b1, rnd128(), 1'b0);
    chk("fill_level", level_o, DEPTH);
    chk("fill_overflow", overflow_o, 1);
    drain(400);
    chk("fill_tx", tx_done - tx0, 9);
    chk("fill_overflow_sticky", overflow_o, 1);

    // Two strobes one cycle apart: no gap between transactions
    reset_dut();
    run = 0;
    step(1'b1, rnd128(), 1'b1);
    step(1'b0, '0, 1'b1);
    if (byte_valid_o) run++;
    step(1'b1, rnd128(), 1'b1);
    if (byte_valid_o) run++;
    for (int i = 0; i < 3 * NB; i++) begin
      step(1'b0, '0, 1'b1);
      if (byte_valid_o) run++;
      else break;
    end
    chk("b2b_run", run, 2 * NB);

    // Asynchronous reset mid-transfer with words queued
    reset_dut();
    for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b1);
    for (int i = 0; i < 20 && !(byte_valid_o && pos == 7); i++) step(1'b0, '0, 1'b1);
    chk("pre_rst_queued", level_o, 3);
    reset_dut();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

`ifdef TRANS_SER_CRC_EN
    step(1'b1, '0, 1'b1);
    drain(60);
    chk("crc_zero", last_byte, 8'h00);
    step(1'b1, {8'h01, 120'h0}, 1'b1);
    drain(60);
    chk("crc_b0", last_byte, crc_ref({8'h01, 120'h0}));
`endif

    // Random traffic, then a stretch of heavy backpressure to force drops
    reset_dut();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, rnd128(), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 120; i++)
      step($urandom_range(0, 1) == 0, rnd128(), $urandom_range(0, 7) == 0);
    drain(400);
    chk("rand_level_end", level_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
